mem_port_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one single-ported data memory among NREQ requesters (e.g. load/store queue, instruction fetch, debug/DMA).
- Each requester presents a level-held request. The arbiter grants one at a time, drives the memory port until acknowledge or timeout, then returns a one-cycle ack with read data to the winner.
- Sits between the requesters and the memory model/controller.

---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one single-ported data memory among NREQ requesters.
// Grants one requester at a time, holds the memory request until m_ack or timeout, then pulses ack.
module mem_port_arbiter #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned GW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      we,
    input  logic [NREQ*32-1:0]   addr,
    input  logic [NREQ*32-1:0]   wdata,
    output logic [NREQ-1:0]      ack,
    output logic [31:0]          rdata,
    output logic                 err,
    output logic                 busy,
    output logic [GW-1:0]        grant_id,
    output logic                 m_req,
    output logic                 m_we,
    output logic [31:0]          m_addr,
    output logic [31:0]          m_wdata,
    input  logic                 m_ack,
    input  logic [31:0]          m_rdata
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [GW-1:0]      last, last_nxt;
    logic [GW-1:0]      gid_nxt;
    logic               m_req_nxt, m_we_nxt, err_nxt, busy_nxt;
    logic [31:0]        m_addr_nxt, m_wdata_nxt, rdata_nxt;
    logic [NREQ-1:0]    ack_nxt;

    logic [GW-1:0]      pick;
    logic               sel_we;
    logic [31:0]        sel_addr, sel_wdata;
    int unsigned        rr_dist, rr_best;
    logic               timeout_hit;

    // Round-robin pick: smallest distance after the last served requester wins.
    always_comb begin
        rr_best   = NREQ;
        rr_dist   = 0;
        pick      = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            rr_dist = (i + 2 * NREQ - 32'(last) - 1) % NREQ;
            if (req[i] && (rr_dist < rr_best)) begin
                rr_best = rr_dist;
                pick    = GW'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick == GW'(i)) begin
                sel_we    = we[i];
                sel_addr  = addr[32*i +: 32];
                sel_wdata = wdata[32*i +: 32];
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (32'(cnt) == TIMEOUT - 1);

    // Next-state and next-output logic.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        last_nxt    = last;
        gid_nxt     = grant_id;
        m_req_nxt   = m_req;
        m_we_nxt    = m_we;
        m_addr_nxt  = m_addr;
        m_wdata_nxt = m_wdata;
        ack_nxt     = ack;
        rdata_nxt   = rdata;
        err_nxt     = err;
        case (state)
            S_IDLE: begin
                if (|req) begin
                    state_nxt   = S_BUSY;
                    m_req_nxt   = 1'b1;
                    gid_nxt     = pick;
                    cnt_nxt     = '0;
                    m_we_nxt    = sel_we;
                    m_addr_nxt  = sel_addr;
                    m_wdata_nxt = sel_wdata;
                end
            end
            S_BUSY: begin
                if (m_ack) begin
                    state_nxt = S_DONE;
                    m_req_nxt = 1'b0;
                    ack_nxt   = NREQ'(1) << grant_id;
                    rdata_nxt = m_we ? 32'h0 : m_rdata;
                    err_nxt   = 1'b0;
                    last_nxt  = grant_id;
                end else if (timeout_hit) begin
                    state_nxt = S_DONE;
                    m_req_nxt = 1'b0;
                    ack_nxt   = NREQ'(1) << grant_id;
                    rdata_nxt = 32'h0;
                    err_nxt   = 1'b1;
                    last_nxt  = grant_id;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                ack_nxt   = '0;
                err_nxt   = 1'b0;
                rdata_nxt = 32'h0;
            end
            default: begin
                state_nxt = S_IDLE;
                m_req_nxt = 1'b0;
                ack_nxt   = '0;
            end
        endcase
        busy_nxt = (state_nxt != S_IDLE);
    end

    // State and output registers; reset level is high on rst_n.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            last     <= GW'(NREQ - 1);
            grant_id <= '0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            ack      <= '0;
            rdata    <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            last     <= last_nxt;
            grant_id <= gid_nxt;
            m_req    <= m_req_nxt;
            m_we     <= m_we_nxt;
            m_addr   <= m_addr_nxt;
            m_wdata  <= m_wdata_nxt;
            ack      <= ack_nxt;
            rdata    <= rdata_nxt;
            err      <= err_nxt;
            busy     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model compared every cycle plus directed literal checks.
module tb_mem_port_arbiter;

    localparam int NREQ = 2;
    localparam int TO   = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req, we;
    logic [63:0]       addr, wdata;
    logic [1:0]        ack;
    logic [31:0]       rdata;
    logic              err, busy;
    logic [0:0]        grant_id;
    logic              m_req, m_we;
    logic [31:0]       m_addr, m_wdata;
    logic              m_ack;
    logic [31:0]       m_rdata;

    mem_port_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .err(err), .busy(busy), .grant_id(grant_id),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: m_ack on the lat-th cycle of m_req (0 = never); spur drives m_ack while idle.
    int          lat = 1;
    int          mcnt = 0;
    bit          spur = 1'b0;
    logic [31:0] resp_data = 32'h0;

    always @(negedge clk) begin
        if (m_req) begin
            mcnt++;
            m_ack   = (lat != 0) && (mcnt == lat);
            m_rdata = m_ack ? resp_data : 32'h0;
        end else begin
            mcnt    = 0;
            m_ack   = spur;
            m_rdata = spur ? 32'hBAD0BAD0 : 32'h0;
        end
    end

    // Transaction-level model: who owns the memory, how long it has waited, who was served last.
    int          own, waited, last_m, c;
    bit          in_done, found;
    logic [1:0]  e_ack;
    logic [31:0] e_rdata, e_addr, e_wdata;
    logic        e_err, e_busy, e_mreq, e_we;
    logic [0:0]  e_gid;

    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            own = -1; waited = 0; last_m = NREQ - 1; in_done = 0;
            e_ack = '0; e_rdata = '0; e_addr = '0; e_wdata = '0;
            e_err = 0; e_busy = 0; e_mreq = 0; e_we = 0; e_gid = '0;
        end else if (in_done) begin
            in_done = 0; e_ack = '0; e_err = 0; e_rdata = '0; e_busy = 0;
        end else if (own >= 0) begin
            if (m_ack || waited == TO - 1) begin
                e_err   = !m_ack;
                e_rdata = (m_ack && !e_we) ? m_rdata : 32'h0;
                e_ack   = 2'(1 << own);
                e_mreq  = 0;
                last_m  = own;
                own     = -1;
                in_done = 1;
            end else begin
                waited++;
            end
        end else if (req != 0) begin
            found = 0;
            for (int k = 1; k <= NREQ; k++) begin
                c = (last_m + k) % NREQ;
                if (!found && req[c]) begin
                    found = 1;
                    own   = c;
                end
            end
            waited  = 0;
            e_gid   = 1'(own);
            e_mreq  = 1;
            e_busy  = 1;
            e_we    = we[own];
            e_addr  = addr[own*32 +: 32];
            e_wdata = wdata[own*32 +: 32];
        end
        #1;
        check("ack", 32'(ack), 32'(e_ack));
        check("rdata", rdata, e_rdata);
        check("err", 32'(err), 32'(e_err));
        check("busy", 32'(busy), 32'(e_busy));
        check("grant_id", 32'(grant_id), 32'(e_gid));
        check("m_req", 32'(m_req), 32'(e_mreq));
        if (e_mreq) begin
            check("m_we", 32'(m_we), 32'(e_we));
            check("m_addr", m_addr, e_addr);
            check("m_wdata", m_wdata, e_wdata);
        end
    end

    task automatic bound_fail(input string name);
        checks++;
        $display("FAIL %s actual=expired required=event (t=%0t)", name, $time);
    endtask

    // Wait for a grant, count m_req cycles, and capture the completion pulse.
    task automatic run_txn(input bit drop_early, output int n, output int gid, output int t0,
                           output logic [1:0] a, output logic [31:0] rd, output logic e,
                           output logic w, output logic [31:0] ad, output logic [31:0] wd);
        int guard;
        n = 0; guard = 0; gid = -1; t0 = 0; a = '0; rd = '0; e = 0; w = 0; ad = '0; wd = '0;
        while (!m_req && guard < 100) begin tick(); guard++; end
        if (!m_req) begin bound_fail("txn_grant_wait"); return; end
        gid = int'(grant_id); t0 = cyc; w = m_we; ad = m_addr; wd = m_wdata;
        if (drop_early) req = '0;
        while (m_req && guard < 200) begin n++; tick(); guard++; end
        if (m_req) begin bound_fail("txn_done_wait"); return; end
        a = ack; rd = rdata; e = err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    int          n, gid, t0, prev_t0, guard;
    logic [1:0]  a;
    logic [31:0] rd, ad, wd;
    logic        e, w;

    initial begin
        rst_n = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        m_ack = 1'b0; m_rdata = '0;
        repeat (3) tick();
        check("reset_busy", 32'(busy), 0);
        check("reset_m_req", 32'(m_req), 0);
        check("reset_ack", 32'(ack), 0);
        check("reset_grant_id", 32'(grant_id), 0);
        @(negedge clk) rst_n = 1'b0;
        tick();

        // Single read from requester 1, memory answers after 3 cycles.
        lat = 3; resp_data = 32'hDEADBEEF;
        addr[63:32] = 32'h100; req = 2'b10;
        run_txn(0, n, gid, t0, a, rd, e, w, ad, wd);
        req = '0;
        check("read_m_addr", ad, 32'h100);
        check("read_gid", 32'(gid), 1);
        check("read_mreq_cycles", 32'(n), 3);
        check("read_ack", 32'(a), 32'h2);
        check("read_rdata", rd, 32'hDEADBEEF);
        check("read_err", 32'(e), 0);
        repeat (2) tick();
        check("read_busy_after", 32'(busy), 0);

        // Store from requester 0, which drops req mid-transaction.
        lat = 2; resp_data = 32'hCAFEF00D;
        we = 2'b01; addr[31:0] = 32'h40; wdata[31:0] = 32'h12345678; req = 2'b01;
        run_txn(1, n, gid, t0, a, rd, e, w, ad, wd);
        req = '0; we = '0;
        check("store_m_we", 32'(w), 1);
        check("store_m_addr", ad, 32'h40);
        check("store_m_wdata", wd, 32'h12345678);
        check("store_ack", 32'(a), 32'h1);
        check("store_rdata", rd, 32'h0);
        check("store_mreq_cycles", 32'(n), 2);

        // Timeout: memory never answers.
        lat = 0; req = 2'b01;
        run_txn(0, n, gid, t0, a, rd, e, w, ad, wd);
        req = '0;
        check("timeout_mreq_cycles", 32'(n), 8);
        check("timeout_err", 32'(e), 1);
        check("timeout_rdata", rd, 32'h0);
        check("timeout_ack", 32'(a), 32'h1);

        // Next request after a timeout completes normally.
        lat = 1; resp_data = 32'h11112222; req = 2'b01;
        run_txn(0, n, gid, t0, a, rd, e, w, ad, wd);
        req = '0;
        check("post_timeout_err", 32'(e), 0);
        check("post_timeout_cycles", 32'(n), 1);
        check("post_timeout_rdata", rd, 32'h11112222);

        // Idle m_ack pulses must be ignored.
        spur = 1'b1;
        repeat (4) tick();
        check("spur_busy", 32'(busy), 0);
        check("spur_ack", 32'(ack), 0);

        // m_ack on the expiry cycle wins; m_ack also toggled in IDLE/DONE around it.
        lat = 8; resp_data = 32'hA5A5A5A5; req = 2'b10;
        run_txn(0, n, gid, t0, a, rd, e, w, ad, wd);
        req = '0;
        check("race_cycles", 32'(n), 8);
        check("race_err", 32'(e), 0);
        check("race_rdata", rd, 32'hA5A5A5A5);
        check("race_ack", 32'(a), 32'h2);
        tick();
        check("done_ignores_m_ack", 32'(ack), 0);
        spur = 1'b0;
        repeat (2) tick();

        // Reset asserted during the second BUSY cycle aborts the transaction at once.
        lat = 0; req = 2'b01; guard = 0;
        while (!m_req && guard < 50) begin tick(); guard++; end
        if (!m_req) bound_fail("abort_grant_wait");
        tick();
        #3 rst_n = 1'b1;
        #1;
        check("abort_m_req", 32'(m_req), 0);
        check("abort_ack", 32'(ack), 0);
        check("abort_busy", 32'(busy), 0);
        req = 2'b11; lat = 1; resp_data = 32'h00000077;
        @(negedge clk) rst_n = 1'b0;

        // Contention straight out of reset: alternating grants every 3 cycles.
        prev_t0 = 0;
        for (int i = 0; i < 4; i++) begin
            run_txn(0, n, gid, t0, a, rd, e, w, ad, wd);
            check("contend_gid", 32'(gid), 32'(i % 2));
            check("contend_ack", 32'(a), 32'(1 << (i % 2)));
            check("contend_err", 32'(e), 0);
            if (i > 0) check("contend_period", 32'(t0 - prev_t0), 3);
            prev_t0 = t0;
        end
        req = '0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
